// File: rtl/div_result_bcd.sv
// Captures the divider quotient or remainder on a rising ready level and converts it to packed BCD,
// one bit per clock. Optional DIV_RESULT_SEG7_EN adds an active-low seven-segment output.
module div_result_bcd #(
    parameter int DW = 16,
    parameter int ND = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ready_in,
    input  logic [DW-1:0]   result_in,
    input  logic [DW-1:0]   remainder_in,
    input  logic            sel_rem,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd_out
`ifdef DIV_RESULT_SEG7_EN
    ,
    output logic [7*ND-1:0] seg_out
`endif
);

    localparam int AW = 4 * ND;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state;
    logic            ready_q;
    logic            start_evt;
    logic [DW-1:0]   bin_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_adj;
    logic [CW-1:0]   cnt_q;

    assign start_evt = ready_in & ~ready_q;

    always_comb begin
        // NOTE: default first so every path assigns acc_adj and no latch is inferred.
        acc_adj = acc_q;
        for (int d = 0; d < ND; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
    end

`ifdef DIV_RESULT_SEG7_EN
    // Segment order {g,f,e,d,c,b,a}, low = lit; non-decimal codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction
`endif

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
`ifdef DIV_RESULT_SEG7_EN
            seg_out <= '1;
`endif
        end else begin
            ready_q <= ready_in;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_evt)
                        state <= LOAD;
                end
                LOAD: begin
                    bin_q <= sel_rem ? remainder_in : result_in;
                    acc_q <= '0;
                    cnt_q <= '0;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    // Overflow out of the top digit is dropped by the shift.
                    {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_out <= acc_q;
`ifdef DIV_RESULT_SEG7_EN
                    for (int d = 0; d < ND; d++)
                        seg_out[7*d +: 7] <= seg7(acc_q[4*d +: 4]);
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: arithmetic BCD model with per-cycle compare plus directed literal checks.
module tb_div_result_bcd;

    localparam int DW = 16;
    localparam int ND = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            ready_in;
    logic [DW-1:0]   result_in;
    logic [DW-1:0]   remainder_in;
    logic            sel_rem;
    logic            busy;
    logic            done;
    logic [4*ND-1:0] bcd_out;
`ifdef DIV_RESULT_SEG7_EN
    logic [7*ND-1:0] seg_out;
`endif

    div_result_bcd #(.DW(DW), .ND(ND)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready_in     (ready_in),
        .result_in    (result_in),
        .remainder_in (remainder_in),
        .sel_rem      (sel_rem),
        .busy         (busy),
        .done         (done),
        .bcd_out      (bcd_out)
`ifdef DIV_RESULT_SEG7_EN
        ,
        .seg_out      (seg_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int unsigned v);
        logic [4*ND-1:0] r;
        r = '0;
        for (int d = 0; d < ND; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Model: transaction timeline counted in edges since the accepted rising edge.
    bit              m_active;
    int              m_k;
    bit              m_rq;
    logic [DW-1:0]   m_op;
    logic            m_busy;
    logic            m_done;
    logic [4*ND-1:0] m_bcd;
`ifdef DIV_RESULT_SEG7_EN
    logic [6:0]      seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [7*ND-1:0] m_seg;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0;
            m_k      = 0;
            m_rq     = 0;
            m_op     = '0;
            m_busy   = 0;
            m_done   = 0;
            m_bcd    = '0;
`ifdef DIV_RESULT_SEG7_EN
            m_seg    = '1;
`endif
        end else begin
            m_done = 0;
            if (m_active) begin
                m_k++;
                if (m_k == 1) begin
                    m_op   = sel_rem ? remainder_in : result_in;
                    m_busy = 1;
                end
                if (m_k == DW + 2) begin
                    m_busy   = 0;
                    m_done   = 1;
                    m_bcd    = to_bcd(int'(m_op));
`ifdef DIV_RESULT_SEG7_EN
                    for (int d = 0; d < ND; d++)
                        m_seg[7*d +: 7] = seg_tab[m_bcd[4*d +: 4]];
`endif
                    m_active = 0;
                end
            end else if (ready_in && !m_rq) begin
                m_active = 1;
                m_k      = 0;
            end
            m_rq = ready_in;
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("bcd_out", 64'(bcd_out), 64'(m_bcd));
`ifdef DIV_RESULT_SEG7_EN
        check("seg_out", 64'(seg_out), 64'(m_seg));
`endif
    end

    task automatic start(input logic [DW-1:0] res, input logic [DW-1:0] rem, input logic sel);
        @(negedge clk);
        ready_in     = 1'b0;
        result_in    = res;
        remainder_in = rem;
        sel_rem      = sel;
        repeat (2) @(negedge clk);
        ready_in = 1'b1;
    endtask

    // Counts edges from the next posedge until done is seen; -1 on timeout.
    task automatic wait_done(input int budget, output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic convert(input string name, input logic [DW-1:0] res, input logic [DW-1:0] rem,
                           input logic sel, input logic [4*ND-1:0] exp);
        int lat;
        int bc;
        start(res, rem, sel);
        wait_done(60, lat, bc);
        check({name, "_latency"}, 64'(lat), 64'(18));
        check({name, "_busy_cycles"}, 64'(bc), 64'(17));
        check({name, "_bcd"}, 64'(bcd_out), 64'(exp));
        @(posedge clk);
        #1;
        check({name, "_done_single"}, 64'(done), 64'(0));
    endtask

    initial begin
        int lat;
        int bc;
        int n;
        rst          = 1'b1;
        ready_in     = 1'b0;
        result_in    = '0;
        remainder_in = '0;
        sel_rem      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_bcd", 64'(bcd_out), 64'(0));
`ifdef DIV_RESULT_SEG7_EN
        check("reset_seg", 64'(seg_out), 64'({7*ND{1'b1}}));
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        convert("quot_12345", 16'd12345, 16'd0, 1'b0, 20'h12345);
        convert("max_65535", 16'd65535, 16'd0, 1'b0, 20'h65535);
        convert("zero", 16'd0, 16'd1, 1'b0, 20'h00000);
        convert("rem_plain", 16'd999, 16'd4096, 1'b1, 20'h04096);

        // Remainder select with operand/select changes mid-SHIFT.
        start(16'd999, 16'd7, 1'b1);
        repeat (8) @(negedge clk);
        sel_rem      = 1'b0;
        remainder_in = 16'd321;
        result_in    = 16'd555;
        wait_done(60, lat, bc);
        check("rem_toggle_seen", 64'(lat >= 0), 64'(1));
        check("rem_toggle_bcd", 64'(bcd_out), 64'(20'h00007));

        // Level held high for 40 cycles gives one conversion.
        start(16'd909, 16'd0, 1'b0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        ready_in = 1'b0;
        check("held_high_done_count", 64'(n), 64'(1));
        check("held_high_bcd", 64'(bcd_out), 64'(20'h00909));

        // Second rising edge during SHIFT is ignored.
        start(16'd4321, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        ready_in = 1'b0;
        repeat (3) @(negedge clk);
        ready_in  = 1'b1;
        result_in = 16'd1111;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n++;
        end
        ready_in = 1'b0;
        check("retrigger_done_count", 64'(n), 64'(1));
        check("retrigger_bcd", 64'(bcd_out), 64'(20'h04321));

        // Reset in the middle of SHIFT.
        start(16'd5555, 16'd0, 1'b0);
        repeat (11) @(posedge clk);
        #2;
        rst      = 1'b1;
        ready_in = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_bcd", 64'(bcd_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        check("post_rst_quiet", 64'(n), 64'(0));

        convert("eighty", 16'd80, 16'd0, 1'b0, 20'h00080);
`ifdef DIV_RESULT_SEG7_EN
        check("seg_eighty", 64'(seg_out), 64'({7'h40, 7'h40, 7'h40, 7'h00, 7'h40}));
`endif
        convert("rem_10009", 16'd1, 16'd10009, 1'b1, 20'h10009);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_result_bcd.md
Name:
div_result_bcd

Overview:
- Downstream stage of the 16-bit divider.
- Waits for the divider's ready level to rise, then captures either the quotient or the remainder.
- Converts the captured value to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Drives the board display path and presents a one-cycle done strobe per completed conversion.

Parameters:
- DW, 16, operand width; matches the divider datapath width from mdr_pkg.
- ND, 5, number of BCD digits produced. Must satisfy 10^ND > 2^DW−1; this is not checked in RTL.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ready_in  input  1  divider Ready level; a rising edge starts a conversion.
- result_in  input  DW  divider quotient.
- remainder_in  input  DW  divider remainder.
- sel_rem  input  1  0 = convert quotient, 1 = convert remainder; sampled only at capture.
- busy  output  1  high from capture through the last shift cycle.
- done  output  1  one-cycle strobe; bcd_out is valid and updated in this cycle.
- bcd_out  output  4*ND  packed BCD; digit 0 (units) in bits [3:0]. Holds its value between conversions.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high on rst. Already decided.
- Reset values:
  - FSM = IDLE; busy = 0, done = 0, bcd_out = 0.
  - Internal shift register, BCD accumulator and bit counter = 0.
  - Edge-detect flop ready_q = 0. A ready_in already high at reset release is therefore treated as a rising edge and triggers one conversion.
- Edge detect: start_evt = ready_in & ~ready_q; ready_q is updated every clock.
- FSM states IDLE, LOAD, SHIFT, DONE:
  - IDLE: on start_evt → LOAD. Otherwise stay.
  - LOAD (1 cycle):
    - Bin reg ← sel_rem ? remainder_in : result_in.
    - Accumulator ← 0; counter ← 0; busy = 1.
    - → SHIFT.
  - SHIFT (exactly DW cycles):
    - First, every accumulator digit ≥ 5 gets +3, all digits in parallel.
    - Then {acc, bin} shifts left by 1; the bin MSB enters acc bit 0.
    - Counter increments each cycle; when counter = DW−1 → DONE. busy = 1.
  - DONE (1 cycle): bcd_out ← acc; done = 1; busy = 0; → IDLE.
- Latency:
  - start_evt sampled at edge T → LOAD during T..T+1 → SHIFT for DW cycles → done high in cycle T+DW+2.
  - bcd_out changes on the same edge that raises done.
  - With DW=16, done asserts 18 cycles after the capture edge.
- start_evt while in LOAD, SHIFT or DONE: ignored, not queued. ready_q still tracks ready_in, so a level that stays high does not retrigger.
- Operand changes after LOAD have no effect on the conversion in progress.
- rst mid-conversion: all state returns to reset values immediately. bcd_out clears to 0 and no done is produced.
- Arithmetic:
  - Add-3 is done per 4-bit digit, with no carry between digits.
  - The accumulator is 4*ND bits. Bits shifted out of the top digit are dropped, which only happens when the ND constraint is violated.

Optional Feature:
- Macro: DIV_RESULT_SEG7_EN.
- When defined:
  - Adds output seg_out, 7*ND bits: active-low segments {g,f,e,d,c,b,a} per digit, digit 0 in [6:0].
  - Registered alongside bcd_out, updated on the same edge as done, reset value all 1s (blank).
  - Codes 10–15 cannot occur; decode them as blank (7'h7F).
- When undefined: the seg_out port and its logic are absent. All other behaviour is identical.

Test Plan:
- Quotient conversion: result_in=12345, sel_rem=0, ready_in 0→1 → done exactly 18 cycles after the capture edge, bcd_out=20'h12345, busy high for 17 cycles.
- Maximum value: result_in=65535 → bcd_out=20'h65535. Then result_in=0 with a new ready_in edge → bcd_out=20'h00000, done single-cycle.
- Remainder select: sel_rem=1, remainder_in=7, result_in=999 → bcd_out=20'h00007. Toggle sel_rem mid-SHIFT → result unchanged.
- Edge handling:
  - ready_in held high for 40 cycles → exactly one done.
  - Second rising edge at cycle 5 of SHIFT → ignored; only one done; bcd_out reflects the first operand.
- Reset mid-operation: assert rst at cycle 9 of SHIFT → busy, done and bcd_out go to 0 asynchronously. After release with ready_in low, no done for 30 cycles.
- With DIV_RESULT_SEG7_EN: result_in=80 → seg_out digit0=7'b1000000, digit1=7'b0000000, digits 2–4=7'b1000000. seg_out=all 1s after reset.
